// File: rtl/y86_regfile.sv
// rtl/y86_regfile.sv - Y86-64 architectural register file: two combinational read ports,
// dual writeback ports (M over E on collision), registered debug read and write counter.
module y86_regfile #(
    parameter int            NREG     = 15,
    parameter int            DW       = 64,
    parameter logic [DW-1:0] RSP_INIT = '0
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [3:0]    d_srcA_i,
    input  logic [3:0]    d_srcB_i,
    output logic [DW-1:0] d_rvalA_o,
    output logic [DW-1:0] d_rvalB_o,
    input  logic [3:0]    W_dstE_i,
    input  logic [DW-1:0] W_valE_i,
    input  logic [3:0]    W_dstM_i,
    input  logic [DW-1:0] W_valM_i,
    input  logic          W_we_i,
    input  logic [3:0]    dbg_addr_i,
    output logic [DW-1:0] dbg_data_o,
    output logic [31:0]   wr_cnt_o
);

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic [DW-1:0] dbg_data_q, dbg_data_d;
    logic [31:0]   wr_cnt_q, wr_cnt_d;
    logic          we_e, we_m;

    // IDs outside the file (RNONE) fall through every match and read as zero.
    always_comb begin
        d_rvalA_o  = '0;
        d_rvalB_o  = '0;
        dbg_data_d = '0;
        for (int i = 0; i < NREG; i++) begin
            if (d_srcA_i == 4'(i))   d_rvalA_o  = regs_q[i];
            if (d_srcB_i == 4'(i))   d_rvalB_o  = regs_q[i];
            if (dbg_addr_i == 4'(i)) dbg_data_d = regs_q[i];
        end
    end

    // Port E yields to port M on a shared destination, matching valM forwarding priority.
    always_comb begin
        we_m = W_we_i && (int'(W_dstM_i) < NREG);
        we_e = W_we_i && (int'(W_dstE_i) < NREG) && (W_dstE_i != W_dstM_i);
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (we_e && W_dstE_i == 4'(i)) regs_d[i] = W_valE_i;
            if (we_m && W_dstM_i == 4'(i)) regs_d[i] = W_valM_i;
        end
        wr_cnt_d = wr_cnt_q + 32'(we_e) + 32'(we_m);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= (i == 4) ? RSP_INIT : '0;
            end
            dbg_data_q <= '0;
            wr_cnt_q   <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            dbg_data_q <= dbg_data_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    assign dbg_data_o = dbg_data_q;
    assign wr_cnt_o   = wr_cnt_q;

endmodule

// File: tb/tb_y86_regfile.sv
// tb/tb_y86_regfile.sv - scoreboard bench for y86_regfile.
module tb_y86_regfile;

    localparam logic [63:0] RSP = 64'h100;

    logic        clk = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [3:0]  d_srcA_i = 4'h0, d_srcB_i = 4'h0, W_dstE_i = 4'hF, W_dstM_i = 4'hF, dbg_addr_i = 4'h0;
    logic [63:0] W_valE_i = '0, W_valM_i = '0;
    logic        W_we_i = 1'b0;
    logic [63:0] d_rvalA_o, d_rvalB_o, dbg_data_o;
    logic [31:0] wr_cnt_o;

    logic [63:0] exp_q[$];
    logic [63:0] e;
    logic [63:0] mdl [15];
    logic [31:0] cnt_m;
    int          n_vec = 0;
    int          n_err = 0;

    y86_regfile #(.NREG(15), .DW(64), .RSP_INIT(RSP)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i),
        .d_rvalA_o(d_rvalA_o), .d_rvalB_o(d_rvalB_o),
        .W_dstE_i(W_dstE_i), .W_valE_i(W_valE_i),
        .W_dstM_i(W_dstM_i), .W_valM_i(W_valM_i),
        .W_we_i(W_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_data_o(dbg_data_o), .wr_cnt_o(wr_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 15; i++) mdl[i] = (i == 4) ? RSP : 64'h0;
        cnt_m = 0;
    endtask

    function automatic logic [63:0] model_rd(input logic [3:0] id);
        return (id == 4'hF) ? 64'h0 : mdl[id];
    endfunction

    task automatic model_write(input logic we, input logic [3:0] de, input logic [63:0] ve,
                               input logic [3:0] dm, input logic [63:0] vm);
        if (we) begin
            if (de != 4'hF && de != dm) begin mdl[de] = ve; cnt_m++; end
            if (dm != 4'hF) begin mdl[dm] = vm; cnt_m++; end
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
        W_we_i = we; W_dstE_i = de; W_valE_i = ve; W_dstM_i = dm; W_valM_i = vm;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n_i = 1'b1;
        d_srcA_i = 4'h4; d_srcB_i = 4'h0;
        #1;
        exp_q.push_back(RSP); exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h0);
        e = exp_q.pop_front(); n_vec++;
        if (d_rvalA_o !== e) begin n_err++; $display("FAIL reset_rsp: got %h want %h", d_rvalA_o, e); end
        e = exp_q.pop_front(); n_vec++;
        if (d_rvalB_o !== e) begin n_err++; $display("FAIL reset_r0: got %h want %h", d_rvalB_o, e); end
        e = exp_q.pop_front(); n_vec++;
        if (64'(wr_cnt_o) !== e) begin n_err++; $display("FAIL reset_cnt: got %h want %h", wr_cnt_o, e); end
        e = exp_q.pop_front(); n_vec++;
        if (dbg_data_o !== e) begin n_err++; $display("FAIL reset_dbg: got %h want %h", dbg_data_o, e); end
    endtask

    task automatic test_dual_write();
        @(negedge clk);
        drive(1'b1, 4'h2, 64'hAA, 4'h3, 64'hBB);
        dbg_addr_i = 4'h2;
        exp_q.push_back(model_rd(4'h2));
        model_write(1'b1, 4'h2, 64'hAA, 4'h3, 64'hBB);
        exp_q.push_back(64'hAA); exp_q.push_back(64'hBB); exp_q.push_back(64'(cnt_m));
        @(negedge clk);
        drive(1'b0, 4'hF, 0, 4'hF, 0);
        d_srcA_i = 4'h2; d_srcB_i = 4'h3;
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (dbg_data_o !== e) begin n_err++; $display("FAIL dbg_prewrite: got %h want %h", dbg_data_o, e); end
        e = exp_q.pop_front(); n_vec++;
        if (d_rvalA_o !== e) begin n_err++; $display("FAIL dual_r2: got %h want %h", d_rvalA_o, e); end
        e = exp_q.pop_front(); n_vec++;
        if (d_rvalB_o !== e) begin n_err++; $display("FAIL dual_r3: got %h want %h", d_rvalB_o, e); end
        e = exp_q.pop_front(); n_vec++;
        if (64'(wr_cnt_o) !== e) begin n_err++; $display("FAIL dual_cnt: got %h want %h", wr_cnt_o, e); end
        exp_q.push_back(64'hAA);
        @(negedge clk);
        e = exp_q.pop_front(); n_vec++;
        if (dbg_data_o !== e) begin n_err++; $display("FAIL dbg_postwrite: got %h want %h", dbg_data_o, e); end
    endtask

    task automatic test_collision();
        @(negedge clk);
        drive(1'b1, 4'h4, 64'h108, 4'h4, 64'hDEAD);
        model_write(1'b1, 4'h4, 64'h108, 4'h4, 64'hDEAD);
        exp_q.push_back(64'hDEAD); exp_q.push_back(64'(cnt_m));
        @(negedge clk);
        drive(1'b0, 4'hF, 0, 4'hF, 0);
        d_srcA_i = 4'h4;
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (d_rvalA_o !== e) begin n_err++; $display("FAIL collide_val: got %h want %h", d_rvalA_o, e); end
        e = exp_q.pop_front(); n_vec++;
        if (64'(wr_cnt_o) !== e) begin n_err++; $display("FAIL collide_cnt: got %h want %h", wr_cnt_o, e); end
    endtask

    task automatic test_same_cycle_read();
        @(negedge clk);
        drive(1'b1, 4'hF, 0, 4'h5, 64'h1);
        model_write(1'b1, 4'hF, 0, 4'h5, 64'h1);
        @(negedge clk);
        drive(1'b1, 4'h5, 64'h7, 4'hF, 0);
        d_srcB_i = 4'h5;
        exp_q.push_back(model_rd(4'h5));
        model_write(1'b1, 4'h5, 64'h7, 4'hF, 0);
        exp_q.push_back(64'h7); exp_q.push_back(64'(cnt_m));
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (d_rvalB_o !== e) begin n_err++; $display("FAIL same_cycle_old: got %h want %h", d_rvalB_o, e); end
        @(negedge clk);
        drive(1'b0, 4'hF, 0, 4'hF, 0);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (d_rvalB_o !== e) begin n_err++; $display("FAIL same_cycle_new: got %h want %h", d_rvalB_o, e); end
        e = exp_q.pop_front(); n_vec++;
        if (64'(wr_cnt_o) !== e) begin n_err++; $display("FAIL same_cycle_cnt: got %h want %h", wr_cnt_o, e); end
    endtask

    task automatic test_disabled_writes();
        @(negedge clk);
        drive(1'b0, 4'h1, 64'hFF, 4'hF, 0);
        model_write(1'b0, 4'h1, 64'hFF, 4'hF, 0);
        @(negedge clk);
        drive(1'b1, 4'hF, 64'hFF, 4'hF, 64'hFF);
        model_write(1'b1, 4'hF, 64'hFF, 4'hF, 64'hFF);
        exp_q.push_back(model_rd(4'h1)); exp_q.push_back(64'(cnt_m)); exp_q.push_back(64'h0);
        @(negedge clk);
        drive(1'b0, 4'hF, 0, 4'hF, 0);
        d_srcA_i = 4'h1; d_srcB_i = 4'hF;
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (d_rvalA_o !== e) begin n_err++; $display("FAIL we0_r1: got %h want %h", d_rvalA_o, e); end
        e = exp_q.pop_front(); n_vec++;
        if (64'(wr_cnt_o) !== e) begin n_err++; $display("FAIL noop_cnt: got %h want %h", wr_cnt_o, e); end
        e = exp_q.pop_front(); n_vec++;
        if (d_rvalB_o !== e) begin n_err++; $display("FAIL rnone_read: got %h want %h", d_rvalB_o, e); end
        d_srcA_i = 4'hF; #1;
        n_vec++;
        if (d_rvalA_o !== 64'h0) begin n_err++; $display("FAIL rnone_readA: got %h want 0", d_rvalA_o); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  de, dm, sa, sb;
        logic [63:0] ve, vm;
        logic        we;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            de = 4'($urandom_range(0, 15)); dm = (k % 5 == 0) ? de : 4'($urandom_range(0, 15));
            ve = {$urandom, $urandom}; vm = {$urandom, $urandom};
            we = ($urandom_range(0, 3) != 0);
            drive(we, de, ve, dm, vm);
            model_write(we, de, ve, dm, vm);
            sa = 4'($urandom_range(0, 15)); sb = 4'($urandom_range(0, 15));
            exp_q.push_back(model_rd(sa)); exp_q.push_back(model_rd(sb)); exp_q.push_back(64'(cnt_m));
            @(posedge clk);
            #1;
            d_srcA_i = sa; d_srcB_i = sb;
            #1;
            e = exp_q.pop_front(); n_vec++;
            if (d_rvalA_o !== e) begin n_err++; $display("FAIL b2b_rA[%0d] id %0d: got %h want %h", k, sa, d_rvalA_o, e); end
            e = exp_q.pop_front(); n_vec++;
            if (d_rvalB_o !== e) begin n_err++; $display("FAIL b2b_rB[%0d] id %0d: got %h want %h", k, sb, d_rvalB_o, e); end
            e = exp_q.pop_front(); n_vec++;
            if (64'(wr_cnt_o) !== e) begin n_err++; $display("FAIL b2b_cnt[%0d]: got %h want %h", k, wr_cnt_o, e); end
        end
        @(negedge clk);
        drive(1'b0, 4'hF, 0, 4'hF, 0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(1'b1, 4'h6, 64'h66, 4'hF, 0);
        @(negedge clk);
        drive(1'b1, 4'h6, 64'h77, 4'hF, 0);
        d_srcA_i = 4'h6; d_srcB_i = 4'h4; dbg_addr_i = 4'h6;
        #2;
        rst_n_i = 1'b0;
        model_reset();
        exp_q.push_back(model_rd(4'h6)); exp_q.push_back(64'h0); exp_q.push_back(64'(cnt_m));
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (d_rvalA_o !== e) begin n_err++; $display("FAIL arst_r6: got %h want %h", d_rvalA_o, e); end
        e = exp_q.pop_front(); n_vec++;
        if (dbg_data_o !== e) begin n_err++; $display("FAIL arst_dbg: got %h want %h", dbg_data_o, e); end
        e = exp_q.pop_front(); n_vec++;
        if (64'(wr_cnt_o) !== e) begin n_err++; $display("FAIL arst_cnt: got %h want %h", wr_cnt_o, e); end
        @(negedge clk);
        drive(1'b0, 4'hF, 0, 4'hF, 0);
        rst_n_i = 1'b1;
        exp_q.push_back(model_rd(4'h6)); exp_q.push_back(model_rd(4'h4)); exp_q.push_back(64'(cnt_m));
        @(posedge clk);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (d_rvalA_o !== e) begin n_err++; $display("FAIL arst_post_r6: got %h want %h", d_rvalA_o, e); end
        e = exp_q.pop_front(); n_vec++;
        if (d_rvalB_o !== e) begin n_err++; $display("FAIL arst_post_rsp: got %h want %h", d_rvalB_o, e); end
        e = exp_q.pop_front(); n_vec++;
        if (64'(wr_cnt_o) !== e) begin n_err++; $display("FAIL arst_post_cnt: got %h want %h", wr_cnt_o, e); end
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_collision();
        test_same_cycle_read();
        test_disabled_writes();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
